// File: rtl/dla_pkg.sv
// Shared types and lane/width constants for the DLA psum write path.
package dla_pkg;

  localparam int unsigned LANES  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } psum_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/psum_lane_fifo.sv
// Per-lane psum FIFO; a push into a full FIFO is accepted when it is popped in the same cycle.
module psum_lane_fifo
  import dla_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  psum_entry_t              din,
  output psum_entry_t              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  psum_entry_t   mem_q [DEPTH];
  psum_entry_t   mem_d [DEPTH];
  logic          push_ok, pop_ok;

  always_comb begin
    pop_ok  = pop && (count_q != '0);
    push_ok = push && ((count_q != FULL_CNT) || pop_ok);
    mem_d   = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
    end
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  always_comb begin
    dout  = mem_q[rd_ptr_q];
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    count = count_q;
  end

endmodule

// File: rtl/psum_wr_arbiter.sv
// Buffers 16 psum lanes, grants one lane per cycle round-robin to the psum SRAM write port,
// throttles the DLA when a lane nears full, and sequences the end-of-layer drain.
module psum_wr_arbiter
  import dla_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STALL_MARGIN = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           layer_start,
  input  logic                           layer_end,
  input  logic [LANES-1:0]               psum_valid,
  input  logic [LANES-1:0][ADDR_W-1:0]   psum_addr,
  input  logic [LANES-1:0][DATA_W-1:0]   psum_data,
  input  logic                           sram_ready,
  output logic                           sram_we,
  output logic [ADDR_W-1:0]              sram_addr,
  output logic [DATA_W-1:0]              sram_wdata,
  output logic                           dla_stall,
  output logic                           layer_done,
  output logic                           busy,
  output logic                           overflow_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned LW = $clog2(LANES);
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - STALL_MARGIN);

  logic [LANES-1:0] fifo_full, fifo_empty, pop;
  psum_entry_t      fifo_dout  [LANES];
  logic [CW-1:0]    fifo_count [LANES];

  arb_state_e        state_q, state_d;
  logic [LW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic              dla_stall_q, dla_stall_d;
  logic              overflow_q, overflow_d;

  logic              grant_vld;
  logic [LW-1:0]     grant_idx;
  logic              push_lost;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    psum_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (psum_valid[g]),
      .pop   (pop[g]),
      .din   ({psum_addr[g], psum_data[g]}),
      .dout  (fifo_dout[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g]),
      .count (fifo_count[g])
    );
  end

  // Round-robin scan starting at rr_ptr; the first non-empty lane wins.
  always_comb begin : arb
    logic [LW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    cand      = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      cand = rr_ptr_q + LW'(k);
      if (sram_ready && !grant_vld && !fifo_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    pop = '0;
    if (grant_vld) begin
      pop[grant_idx] = 1'b1;
    end
  end

  // Stall looks at the counts the FIFOs will hold after this cycle's push/pop.
  always_comb begin : stall_calc
    logic [LW-1:0] lane;
    logic [CW-1:0] post;
    logic          push_ok;
    dla_stall_d = 1'b0;
    lane        = '0;
    post        = '0;
    push_ok     = 1'b0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane    = LW'(k);
      push_ok = psum_valid[lane] && (!fifo_full[lane] || pop[lane]);
      post    = fifo_count[lane] + CW'(push_ok) - CW'(pop[lane]);
      if (post >= STALL_TH) begin
        dla_stall_d = 1'b1;
      end
    end
    push_lost  = |(psum_valid & fifo_full & ~pop);
    overflow_d = (layer_start ? 1'b0 : overflow_q) | push_lost;
  end

  always_comb begin
    rr_ptr_d     = grant_vld ? grant_idx + LW'(1) : rr_ptr_q;
    sram_we_d    = grant_vld;
    sram_addr_d  = grant_vld ? fifo_dout[grant_idx].addr : sram_addr_q;
    sram_wdata_d = grant_vld ? fifo_dout[grant_idx].data : sram_wdata_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (layer_start) state_d = RUN;
      RUN:     if (layer_end) state_d = DRAIN;
      DRAIN:   if ((&fifo_empty) && !grant_vld) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      dla_stall_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      dla_stall_q  <= dla_stall_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    sram_we      = sram_we_q;
    sram_addr    = sram_addr_q;
    sram_wdata   = sram_wdata_q;
    dla_stall    = dla_stall_q;
    overflow_err = overflow_q;
    layer_done   = (state_q == DONE);
    busy         = (state_q == RUN) || (state_q == DRAIN);
  end

endmodule

// File: doc/psum_wr_arbiter.md
Name: psum_wr_arbiter

Overview:
- Sits between the DLA output side (16 psum lanes, each with DLA_out, psum_valid and psum_addr) and the single-write-port psum buffer SRAM.
- Buffers each lane in a small FIFO and grants one lane per cycle to the SRAM port, round-robin.
- Throttles the DLA through a stall signal when any lane FIFO is close to full.
- Sequences layer drain: after the DLA finishes a layer, it signals layer completion only once every buffered psum has been written.

Parameters:
LANES, 16, number of psum lanes
DATA_W, 8, psum data width per lane
ADDR_W, 16, psum address width
DEPTH, 4, entries per lane FIFO (power of 2, >=2)
STALL_MARGIN, 1, dla_stall asserts when any lane count >= DEPTH-STALL_MARGIN

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
layer_start  in  1  pulse; begin a layer
layer_end  in  1  pulse; DLA finished producing psums (driven from all_done_main)
psum_valid  in  [LANES] x 1  per-lane write request
psum_addr  in  [LANES] x ADDR_W  per-lane psum address
psum_data  in  [LANES] x DATA_W  per-lane psum value (DLA_out)
sram_ready  in  1  SRAM port can accept a write in the next cycle
sram_we  out  1  write enable, registered
sram_addr  out  ADDR_W  write address, registered
sram_wdata  out  DATA_W  write data, registered
dla_stall  out  1  registered backpressure to the DLA controller
layer_done  out  1  one-cycle pulse at end of drain
busy  out  1  high in RUN or DRAIN
overflow_err  out  1  sticky; a push was lost

Behaviour:
- Reset (rst==0 at a clk edge), including mid-operation:
  - All FIFOs empty; rr_ptr=0; FSM=IDLE.
  - All outputs 0.
  - The cycle's pushes and pops are discarded.
- Push:
  - psum_valid[i]==1 pushes {psum_addr[i],psum_data[i]} into FIFO i in any FSM state.
  - If FIFO i is full and is not popped in the same cycle, the entry is dropped and overflow_err is set.
  - overflow_err clears only on reset or on layer_start.
  - If FIFO i is full and is popped in the same cycle, the push is accepted.
- Arbitration, combinational on registered FIFO state:
  - When sram_ready==1, grant = first non-empty lane scanning rr_ptr, rr_ptr+1, ... mod LANES.
  - The granted FIFO pops. Next cycle: sram_we=1, with sram_addr/sram_wdata = the popped entry.
  - rr_ptr <= (grant+1) mod LANES after each grant; rr_ptr is unchanged when there is no grant.
  - sram_ready==0 or all FIFOs empty: no pop; next cycle sram_we=0, and addr/wdata hold their last values.
- Latency: a push in cycle t produces sram_we in cycle t+2 at the earliest (no contention, sram_ready high).
- Throughput: at most 1 write per cycle, regardless of the number of lanes.
- dla_stall is registered: next-cycle value = OR over lanes of (count_i >= DEPTH-STALL_MARGIN), evaluated on post-update counts.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: layer_start -> RUN.
  - RUN: layer_end -> DRAIN. layer_start in RUN is ignored.
  - DRAIN: all FIFOs empty and no grant this cycle -> DONE.
  - DONE: layer_done=1 for exactly this cycle -> IDLE.
  - Simultaneous layer_start and layer_end in IDLE: layer_start wins (-> RUN); layer_end is ignored.
  - layer_end in IDLE is ignored.
- busy=1 in RUN and DRAIN.
- Width rules: FIFO counts are $clog2(DEPTH)+1 bits; pointers wrap mod DEPTH; rr_ptr is $clog2(LANES) bits and wraps 15->0.

Decomposition:
- dla_pkg holds:
  - LANES, DATA_W, ADDR_W
  - psum_entry_t struct {addr, data}
  - arb_state_e enum {IDLE, RUN, DRAIN, DONE}
- Sub-module psum_lane_fifo: one per lane via generate.
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty, count; same-cycle push+pop supported when full.
- Arbiter, FSM and output registers live in psum_wr_arbiter.

Test Plan:
1. Single write: after layer_start, lane 3 is valid for one cycle with addr 0x0010 and data 0x5A, sram_ready=1 -> exactly one sram_we, 2 cycles later, with addr 0x0010 and data 0x5A.
2. All 16 lanes are valid in one cycle with addr=lane and data=0xA0+lane, rr_ptr=0 -> 16 consecutive sram_we cycles in lane order 0..15, no gaps. dla_stall stays 0 (all counts reach only 1).
3. Round-robin: lanes 2 and 9 are each preloaded with 3 entries, sram_ready=1 -> grant order 2,9,2,9,2,9.
4. Backpressure/overflow: sram_ready=0 while lane 5 pushes 5 consecutive entries (DEPTH=4, STALL_MARGIN=1):
   - dla_stall=1 in the cycle after the 3rd push.
   - The 5th push is dropped and overflow_err=1.
   - After sram_ready=1, exactly 4 writes occur.
5. Drain: 5 entries are pending when layer_end pulses -> busy stays 1 through DRAIN; layer_done pulses exactly once, 1 cycle after the last sram_we cycle; the FSM then returns to IDLE.
6. Reset mid-drain: rst=0 for one cycle with entries pending -> no further sram_we; all outputs 0; FSM in IDLE; the next layer_start begins at rr_ptr=0.
